// File: rtl/mr_emi_arb_if.sv
// EMI bus bundle shared by the I-side, D-side and master ports of mr_emi_arb.
// master drives the request side, slave returns read data and beat valid.
interface mr_emi_arb_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
);
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [1:0]      size;
    logic            RnW;
    logic [DW/8-1:0] bws;
    logic            req;
    logic [DW-1:0]   rdata;
    logic            valid;

    modport master (output addr, wdata, size, RnW, bws, req, input rdata, valid);
    modport slave  (input addr, wdata, size, RnW, bws, req, output rdata, valid);
endinterface

// File: rtl/mr_emi_arb.sv
// mr_emi_arb: merges the I-side (read-only) and D-side EMI ports onto one EMI
// master port. A grant is held until the owner drops req, and every hand-over
// passes through IDLE so the master sees at least one req-low cycle.
// Build option EMI_ARB_DPRIO_EN: D wins every IDLE tie instead of round-robin.
module mr_emi_arb #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
) (
    input  logic         clk,
    input  logic         reset,
    mr_emi_arb_if.slave  i_emi,
    mr_emi_arb_if.slave  d_emi,
    mr_emi_arb_if.master m_emi
);
    localparam int unsigned BW = DW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t        state;
    logic          sel_d;
    logic          pick_d_c;
    logic [AW-1:0] addr_c;
    logic [DW-1:0] wdata_c;
    logic [1:0]    size_c;
    logic          rnw_c;
    logic [BW-1:0] bws_c;

`ifdef EMI_ARB_DPRIO_EN
    // D takes any request it is present for.
    assign pick_d_c = d_emi.req;
`else
    logic last_gnt;

    // D wins when alone, or on a tie when I was the last owner.
    assign pick_d_c = d_emi.req && (!i_emi.req || !last_gnt);
`endif

    // Grant state machine; mux select is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel_d <= 1'b0;
`ifndef EMI_ARB_DPRIO_EN
            last_gnt <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d_c) begin
                        state <= GNT_D;
                        sel_d <= 1'b1;
`ifndef EMI_ARB_DPRIO_EN
                        last_gnt <= 1'b1;
`endif
                    end else if (i_emi.req) begin
                        state <= GNT_I;
                        sel_d <= 1'b0;
`ifndef EMI_ARB_DPRIO_EN
                        last_gnt <= 1'b0;
`endif
                    end
                end
                GNT_I: if (!i_emi.req) state <= IDLE;
                GNT_D: if (!d_emi.req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request-side mux; the I port is presented as a full-width read.
    always_comb begin
        addr_c  = i_emi.addr;
        wdata_c = '0;
        size_c  = i_emi.size;
        rnw_c   = 1'b1;
        bws_c   = {BW{1'b1}};
        if (sel_d) begin
            addr_c  = d_emi.addr;
            wdata_c = d_emi.wdata;
            size_c  = d_emi.size;
            rnw_c   = d_emi.RnW;
            bws_c   = d_emi.bws;
        end
    end

    assign m_emi.addr  = addr_c;
    assign m_emi.wdata = wdata_c;
    assign m_emi.size  = size_c;
    assign m_emi.RnW   = rnw_c;
    assign m_emi.bws   = bws_c;

    // Owner req passes straight through so a drop ends the request that cycle.
    assign m_emi.req = ((state == GNT_I) && i_emi.req) ||
                       ((state == GNT_D) && d_emi.req);

    // Read data is broadcast; only the owner's valid qualifies it.
    assign i_emi.rdata = m_emi.rdata;
    assign d_emi.rdata = m_emi.rdata;
    assign i_emi.valid = (state == GNT_I) && m_emi.valid;
    assign d_emi.valid = (state == GNT_D) && m_emi.valid;
endmodule

// File: tb/tb_mr_emi_arb.sv
// Bench for mr_emi_arb: directed scenarios plus random request rounds,
// checked against a transaction-level grant model.
module tb_mr_emi_arb;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = DW / 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mr_emi_arb_if #(.AW(AW), .DW(DW)) i_if ();
    mr_emi_arb_if #(.AW(AW), .DW(DW)) d_if ();
    mr_emi_arb_if #(.AW(AW), .DW(DW)) m_if ();

    mr_emi_arb #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .i_emi (i_if.slave),
        .d_emi (d_if.slave),
        .m_emi (m_if.master)
    );

    int n_checks;
    int n_fail;

    // Model: pending requests per port and who was granted last.
    bit            pend_i;
    bit            pend_d;
    bit            last_d;
    logic [AW-1:0] ia, da;
    logic [1:0]    isz, dsz;
    logic          drnw;
    logic [BW-1:0] dbws;
    logic [DW-1:0] dwd;
    logic [DW-1:0] rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_i(input logic [AW-1:0] a, input logic [1:0] s);
        ia = a; isz = s;
        i_if.addr = a; i_if.size = s; i_if.req = 1'b1;
        pend_i = 1'b1;
    endtask

    task automatic req_d(input logic [AW-1:0] a, input logic [1:0] s, input logic r,
                         input logic [BW-1:0] b, input logic [DW-1:0] w);
        da = a; dsz = s; drnw = r; dbws = b; dwd = w;
        d_if.addr = a; d_if.size = s; d_if.RnW = r; d_if.bws = b; d_if.wdata = w;
        d_if.req = 1'b1;
        pend_d = 1'b1;
    endtask

    task automatic rand_i();
        req_i(AW'($urandom()), 2'($urandom_range(0, 3)));
    endtask

    task automatic rand_d();
        req_d(AW'($urandom()), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              BW'($urandom()), {$urandom(), $urandom()});
    endtask

    // Grant rule: lone requester wins; a tie goes to the port not served last
    // (or always to D with the priority option).
    function automatic bit pick_d();
        if (pend_i && pend_d) begin
`ifdef EMI_ARB_DPRIO_EN
            return 1'b1;
`else
            return !last_d;
`endif
        end
        return pend_d;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        i_if.req = 1'b0; d_if.req = 1'b0;
        pend_i = 1'b0; pend_d = 1'b0; last_d = 1'b1;
        m_if.valid = 1'b0;
        ia = AW'($urandom()); i_if.addr = ia;
        tick();
        tick();
        m_if.valid = 1'b1;
        @(negedge clk);
        check("rst_m_req",  64'(m_if.req), 64'(0));
        check("rst_ivalid", 64'(i_if.valid), 64'(0));
        check("rst_dvalid", 64'(d_if.valid), 64'(0));
        check("rst_addr",   64'(m_if.addr), 64'(ia));
        check("rst_rnw",    64'(m_if.RnW), 64'(1));
        check("rst_bws",    64'(m_if.bws), 64'({BW{1'b1}}));
        check("rst_wdata",  64'(m_if.wdata), 64'(0));
        tick();
        reset = 1'b0;
        m_if.valid = 1'b0;
        @(negedge clk);
    endtask

    // Owner holds the grant from this cycle: check mux, beats, then drop req.
    task automatic serve(input bit own_d, input int raise_beat);
        int beats;
        int stalls;
        beats = ((own_d ? dsz : isz) == 2'b11) ? 4 : 1;
        @(negedge clk);
        check("grant_req",   64'(m_if.req), 64'(1));
        check("grant_addr",  64'(m_if.addr), 64'(own_d ? da : ia));
        check("grant_size",  64'(m_if.size), 64'(own_d ? dsz : isz));
        check("grant_rnw",   64'(m_if.RnW), 64'(own_d ? drnw : 1'b1));
        check("grant_bws",   64'(m_if.bws), 64'(own_d ? dbws : {BW{1'b1}}));
        check("grant_wdata", 64'(m_if.wdata), 64'(own_d ? dwd : '0));
        for (int b = 0; b < beats; b++) begin
            stalls = int'($urandom_range(0, 2));
            for (int s = 0; s < stalls; s++) begin
                tick();
                m_if.valid = 1'b0;
                @(negedge clk);
                check("stall_req",    64'(m_if.req), 64'(1));
                check("stall_ivalid", 64'(i_if.valid), 64'(0));
                check("stall_dvalid", 64'(d_if.valid), 64'(0));
            end
            tick();
            rd = {$urandom(), $urandom()};
            m_if.rdata = rd;
            m_if.valid = 1'b1;
            if (b == raise_beat) begin
                if (own_d && !pend_i) rand_i();
                else if (!own_d && !pend_d) rand_d();
            end
            @(negedge clk);
            check("beat_ivalid", 64'(i_if.valid), 64'(!own_d));
            check("beat_dvalid", 64'(d_if.valid), 64'(own_d));
            check("beat_irdata", 64'(i_if.rdata), 64'(rd));
            check("beat_drdata", 64'(d_if.rdata), 64'(rd));
            check("beat_addr",   64'(m_if.addr), 64'(own_d ? da : ia));
        end
        tick();
        m_if.valid = 1'b0;
        if (own_d) begin d_if.req = 1'b0; pend_d = 1'b0; end
        else begin i_if.req = 1'b0; pend_i = 1'b0; end
        @(negedge clk);
        check("drop_req", 64'(m_if.req), 64'(0));
    endtask

    // Start an IDLE cycle; m_emi_valid is forced high to prove it is gated.
    task automatic idle_begin();
        tick();
        m_if.valid = 1'b1;
        m_if.rdata = {$urandom(), $urandom()};
    endtask

    task automatic finish_grant(input int raise_beat);
        bit w;
        w = pick_d();
        last_d = w;
        tick();
        m_if.valid = 1'b0;
        serve(w, raise_beat);
    endtask

    task automatic grant(input int raise_beat);
        @(negedge clk);
        check("idle_req",    64'(m_if.req), 64'(0));
        check("idle_ivalid", 64'(i_if.valid), 64'(0));
        check("idle_dvalid", 64'(d_if.valid), 64'(0));
        finish_grant(raise_beat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit wi, wd;
        int rb;
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        pend_i = 1'b0; pend_d = 1'b0; last_d = 1'b1;
        isz = 2'b00; dsz = 2'b00; drnw = 1'b1; dbws = '0; dwd = '0; ia = '0; da = '0; rd = '0;
        i_if.addr = '0; i_if.size = 2'b00; i_if.req = 1'b0;
        i_if.wdata = '0; i_if.RnW = 1'b1; i_if.bws = '0;
        d_if.addr = '0; d_if.size = 2'b00; d_if.req = 1'b0;
        d_if.wdata = '0; d_if.RnW = 1'b1; d_if.bws = '0;
        m_if.rdata = '0; m_if.valid = 1'b0;

        do_reset();

        // I-only cache-line burst.
        idle_begin();
        req_i(32'h0000_0100, 2'b11);
        grant(-1);

        // D-only byte write.
        idle_begin();
        req_d(32'h0000_2003, 2'b00, 1'b0, 8'h08, 64'h1122_3344_5566_7788);
        grant(-1);

        // Simultaneous requests straight after reset.
        do_reset();
        idle_begin();
        rand_i();
        rand_d();
        grant(-1);
        idle_begin();
        grant(-1);

        // Repeated contention: both ports re-request immediately.
        for (int t = 0; t < 6; t++) begin
            idle_begin();
            if (!pend_i) rand_i();
            if (!pend_d) rand_d();
            grant(-1);
        end
        while (pend_i || pend_d) begin
            idle_begin();
            grant(-1);
        end

        // D requests on beat 2 of an I burst.
        idle_begin();
        req_i(32'h0000_0400, 2'b11);
        grant(1);
        idle_begin();
        grant(-1);

        // Reset on beat 1 of a D cache-line read.
        idle_begin();
        req_d(32'h0000_3000, 2'b11, 1'b1, 8'hFF, 64'h0);
        @(negedge clk);
        check("rm_idle_req", 64'(m_if.req), 64'(0));
        last_d = 1'b1;
        tick();
        m_if.valid = 1'b0;
        @(negedge clk);
        check("rm_grant_req", 64'(m_if.req), 64'(1));
        tick();
        m_if.valid = 1'b1;
        @(negedge clk);
        check("rm_beat0_dvalid", 64'(d_if.valid), 64'(1));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_d = 1'b1;
        req_i(32'h0000_0500, 2'b00);
        @(negedge clk);
        check("rm_after_req",    64'(m_if.req), 64'(0));
        check("rm_after_ivalid", 64'(i_if.valid), 64'(0));
        check("rm_after_dvalid", 64'(d_if.valid), 64'(0));
        finish_grant(-1);
        while (pend_i || pend_d) begin
            idle_begin();
            grant(-1);
        end

        // Random request rounds.
        for (int r = 0; r < 30; r++) begin
            wi = 1'($urandom_range(0, 1));
            wd = 1'($urandom_range(0, 1));
            if (!wi && !wd && !pend_i && !pend_d) wi = 1'b1;
            rb = int'($urandom_range(0, 4)) - 1;
            idle_begin();
            if (wi && !pend_i) rand_i();
            if (wd && !pend_d) rand_d();
            grant(rb);
        end
        while (pend_i || pend_d) begin
            idle_begin();
            grant(-1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mr_emi_arb.md
Name: mr_emi_arb

Overview:
- Two-port arbiter that merges the CPU's I-side EMI (read-only) and D-side EMI (read/write) onto one external EMI master port feeding a single shared memory or bus.
- Grants one requester at a time and holds the grant for the whole request, including a 4-beat cache-line burst, until that requester drops req.
- Guarantees at least one req-low cycle downstream between successive requests.
- Sits between mr_cpu_top and the memory/bus interface.

Parameters:
- AW, 32, address width of all EMI ports.
- DW, 64, data width of all EMI ports (bws width = DW/8).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_emi_addr  in  AW  I-side request address
- i_emi_size  in  2  I-side size; 2'b11 = cache-line burst
- i_emi_req  in  1  I-side request; held for the full transfer
- i_emi_rdata  out  DW  I-side read data (direct copy of m_emi_rdata)
- i_emi_valid  out  1  I-side beat valid
- d_emi_addr  in  AW  D-side address
- d_emi_wdata  in  DW  D-side write data
- d_emi_size  in  2  D-side size (1/2/4/CL)
- d_emi_RnW  in  1  D-side 1=read, 0=write
- d_emi_bws  in  DW/8  D-side byte strobes
- d_emi_req  in  1  D-side request
- d_emi_rdata  out  DW  D-side read data (direct copy of m_emi_rdata)
- d_emi_valid  out  1  D-side beat valid
- m_emi_addr  out  AW  master address
- m_emi_wdata  out  DW  master write data
- m_emi_size  out  2  master size
- m_emi_RnW  out  1  master read/write
- m_emi_bws  out  DW/8  master byte strobes
- m_emi_req  out  1  master request
- m_emi_rdata  in  DW  master read data
- m_emi_valid  in  1  master beat valid / write accept

Behaviour:
- State register: IDLE, GNT_I, GNT_D. Register last_gnt (0 = I, 1 = D).
- Reset values:
  - State = IDLE; last_gnt = D, so I wins the first tie.
  - m_emi_req = 0; i_emi_valid = 0; d_emi_valid = 0.
  - Mux select = I; all other outputs follow the mux.
- IDLE:
  - m_emi_req = 0.
  - If only one req is high, go to that port's GNT state next cycle.
  - If both are high, round-robin: grant the port that is not last_gnt.
  - Entering a GNT state updates last_gnt.
- GNT_x, owner req high:
  - m_emi_req = owner req (combinational).
  - addr/size/RnW/bws/wdata are muxed combinationally from the owner.
  - For I, the master sees RnW = 1, bws = all ones, wdata = 0.
- GNT_x, owner req low:
  - m_emi_req = 0 that cycle; next state IDLE.
  - The owner dropping req mid-burst is treated as end of request.
- Latency:
  - req rising in IDLE at cycle N -> m_emi_req high at N+1.
  - Owner req low at T -> earliest next-grant m_emi_req at T+2. This gives a ≥2-cycle downstream gap, meeting the ≥1 requirement.
- Valid routing:
  - owner_valid = m_emi_valid while in GNT_owner; non-owner valid = 0.
  - Both valids are 0 in IDLE.
- Read data:
  - m_emi_rdata is broadcast to both rdata outputs; only the valid lines qualify it.
- The non-owner's req is ignored, not sampled, until the next IDLE. Its inputs must be held stable by that requester.
- No timeouts. The owner can hold the grant indefinitely; the other port waits.
- Reset asserted mid-burst: the next cycle is IDLE with m_emi_req = 0. In-flight beats are dropped and their valids suppressed.
- The mux select is registered with the state. In IDLE, the outputs reflect the last owner (don't-care, since req = 0).

Optional Feature:
- Macro: EMI_ARB_DPRIO_EN.
- Defined: fixed priority replaces round-robin. D wins any IDLE tie. last_gnt is unused and may be optimised out. Starvation of I is accepted.
- Undefined: round-robin as above.

Test Plan:
- I-only CL burst:
  - Stimulus: i_req high, addr 0x100, size 2'b11, 4 m_valid pulses with random stalls.
  - Response: m_req one cycle after i_req; m_addr = 0x100; i_valid mirrors all 4 pulses; d_valid stays 0.
- D-only byte write:
  - Stimulus: d_req, RnW = 0, addr 0x2003, bws 8'h08, wdata 0x11223344_55667788.
  - Response: m_* equal the D inputs; one d_valid; d_req drop -> m_req low the same cycle; state IDLE next cycle.
- Simultaneous requests after reset:
  - Stimulus: i_req and d_req rise together.
  - Response: I granted first; after I drops, D granted exactly 2 cycles later; m_req low between the two grants.
- Repeated contention:
  - Stimulus: both ports re-request immediately for 6 transactions.
  - Response: grants alternate I, D, I, D, I, D. With EMI_ARB_DPRIO_EN defined, D receives all 6 grants while I stays pending.
- Non-owner request during burst:
  - Stimulus: D requests while I is on beat 2 of a CL burst.
  - Response: I completes all 4 beats unaffected; D is granted afterwards; d_valid stays 0 throughout I's burst.
- Reset mid-burst:
  - Stimulus: assert reset on beat 1 of a D CL read.
  - Response: the next cycle has m_req = 0, state IDLE, both valids 0; a new I request is granted normally after reset.
